gray_seq_monitor: RTL and testbench
===================================

Name: gray_seq_monitor

Overview:
- Downstream consumer of the Gray-code counter stage; samples its gray count and zero-marker `sig` every valid cycle.
- Decodes the Gray value to binary and checks that the sequence advances by exactly +1 per sample.
- Checks that `sig` coincides with count zero and tracks wrap-arounds.
- Provides the decoded count and sticky fault status to the system/checker layer.

Parameters:
- CBITS, 13, width of gray input and binary output.
- WRAP_BITS, 8, width of saturating wrap counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_vld  input  1  upstream sample valid; low while upstream is held in reset.
- gray_in  input  CBITS  upstream gray count.
- sig_in  input  1  upstream zero marker.
- clr_err  input  1  clears fault state and re-arms lock.
- bin_out  output  CBITS  registered binary decode of the last valid gray_in.
- bin_vld  output  1  bin_out updated this cycle.
- wrap_cnt  output  WRAP_BITS  saturating count of max->0 transitions.
- wrap_pulse  output  1  one-cycle pulse on each detected wrap.
- locked  output  1  monitor holds a reference sample and has no fault.
- err  output  1  sticky fault flag.
- err_code  output  3  sticky OR of fault causes: bit0 SKIP, bit1 SIGMIS, bit2 STALL.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - clk and rst_n; all state changes on posedge clk only.
  - rst_n=0 at an edge forces: bin_out=0, bin_vld=0, wrap_cnt=0, wrap_pulse=0, locked=0, err=0, err_code=0, prev_bin=0, state UNLOCKED.
  - Reset overrides all other inputs, including mid-sequence.
- Decode: b[CBITS-1]=g[CBITS-1]; b[i]=b[i+1]^g[i]. Combinational, then registered into bin_out on in_vld.
  - Latency 1 cycle: bin_vld = in_vld delayed by one; bin_out holds when in_vld=0.
- Checks, evaluated only on in_vld=1 in LOCKED (b = decoded gray_in, p = prev_bin):
  - STALL: b == p.
  - SKIP: b != p and b != (p+1) mod 2^CBITS. Arithmetic is CBITS wide and wraps; no carry out.
  - SIGMIS: sig_in != (gray_in == 0). This check also applies in UNLOCKED on the seeding sample, but only updates err_code if it fails there.
  - prev_bin <= b on every valid sample in any state.
- State machine (2-bit enum):
  - UNLOCKED: on in_vld, seed prev_bin and go to LOCKED; locked=1 from the next cycle. SIGMIS on the seed sample goes to FAULT instead.
  - LOCKED: on in_vld, any check failing -> FAULT; err=1 and err_code bits set from the next cycle; locked drops the same cycle err rises. Otherwise stay.
  - FAULT: err sticky; further failures OR into err_code. Decode and wrap tracking continue.
- clr_err=1 at an edge, from any state:
  - Clears err and err_code, state -> UNLOCKED, locked=0.
  - The same-cycle sample updates bin_out/prev_bin but is not checked and does not seed lock. The next valid sample seeds.
  - clr_err has priority over any same-cycle failure.
- Wrap: valid sample with p == 2^CBITS-1 and b == 0, only in LOCKED or FAULT.
  - Raises wrap_pulse for exactly one cycle (registered, with bin_vld).
  - Increments wrap_cnt; saturates at 2^WRAP_BITS-1.
  - wrap_cnt is cleared only by reset, not by clr_err.
- in_vld=0 gaps: no checks, no state change; prev_bin retained, so a gap is not a fault.

Decomposition:
- Package gray_mon_pkg:
  - state enum {UNLOCKED, LOCKED, FAULT}.
  - err_code bit index constants ERR_SKIP=0, ERR_SIGMIS=1, ERR_STALL=2.
  - gray2bin function, parameterised by width.
- One natural sub-module: gray_to_bin, combinational CBITS-wide decoder instantiated once.
- Checks, FSM and counters live in the top.

Test Plan (CBITS=4, WRAP_BITS=2):
- Reset then 20 clean samples gray 0,1,3,2,6,... with sig_in=1 only at gray 0:
  - locked=1 from cycle 2.
  - err stays 0.
  - bin_out follows 0..15,0..3 with 1-cycle latency.
  - wrap_pulse once at sample 17; wrap_cnt=1.
- LOCKED at bin 5 (gray 7), next sample gray 5 (bin 6) then gray 13 (bin 9):
  - err=1, err_code=001, locked=0 the cycle after the gray-13 sample.
- Repeated gray 6 twice while LOCKED -> err_code=100.
- Then apply clr_err, then samples 4,5:
  - err=0, err_code=000 after clr_err.
  - locked=1 after the second post-clear sample.
- gray_in=0 with sig_in=0 while LOCKED -> err_code bit1 set.
- gray_in=3 with sig_in=1 in FAULT -> err_code accumulates to 011.
- Five full wraps -> wrap_cnt saturates at 3; wrap_pulse still pulses each wrap.
- Then clr_err -> wrap_cnt stays 3.
- in_vld low 10 cycles mid-sequence, resume with the next count -> no error, bin_vld low during the gap.
- rst_n=0 for one cycle mid-FAULT -> all outputs 0 next cycle; first valid sample re-seeds lock.

Source files
------------

// File: rtl/gray_mon_pkg.sv
// Shared types, fault-code bit positions and the Gray decode helper for the
// Gray-sequence monitor.
package gray_mon_pkg;

  // Monitor lock state
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // Bit positions inside err_code
  localparam int unsigned ERR_SKIP   = 0;
  localparam int unsigned ERR_SIGMIS = 1;
  localparam int unsigned ERR_STALL  = 2;
  localparam int unsigned ERR_BITS   = 3;

  // Widest Gray value the helper decodes; narrower values are zero-extended,
  // which leaves the decode of the low bits unchanged.
  localparam int unsigned GRAY_MAX_W = 32;

  // Gray to binary: top bit copies, each lower bit folds in the bit above.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational W-bit Gray to binary decoder.
module gray_to_bin
  import gray_mon_pkg::*;
#(
  parameter int unsigned W = 13
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  // Widen, decode, and narrow back to W bits
  always_comb begin
    bin_c = W'(gray2bin(GRAY_MAX_W'(gray)));
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray-sequence monitor: decodes the upstream Gray count, checks that it
// advances by exactly one per valid sample, checks the zero marker, and
// counts wrap-arounds. Fault causes accumulate until clr_err.
module gray_seq_monitor
  import gray_mon_pkg::*;
#(
  parameter int unsigned CBITS     = 13,
  parameter int unsigned WRAP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [CBITS-1:0]     gray_in,
  input  logic                 sig_in,
  input  logic                 clr_err,
  output logic [CBITS-1:0]     bin_out,
  output logic                 bin_vld,
  output logic [WRAP_BITS-1:0] wrap_cnt,
  output logic                 wrap_pulse,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_BITS-1:0]  err_code
);

  localparam logic [CBITS-1:0]     CNT_MAX  = '1;
  localparam logic [WRAP_BITS-1:0] WRAP_MAX = '1;

  state_t               state;
  logic [CBITS-1:0]     prev_bin;
  logic [CBITS-1:0]     dec_c;
  logic [CBITS-1:0]     prev_inc_c;
  logic                 stall_c;
  logic                 skip_c;
  logic                 sigmis_c;
  logic                 wrap_c;
  logic [ERR_BITS-1:0]  fail_c;

  gray_to_bin #(
    .W(CBITS)
  ) u_dec (
    .gray  (gray_in),
    .bin_c (dec_c)
  );

  // Sequence, marker and wrap checks on the current sample against prev_bin
  always_comb begin
    prev_inc_c = '0;
    stall_c    = 1'b0;
    skip_c     = 1'b0;
    sigmis_c   = 1'b0;
    wrap_c     = 1'b0;
    fail_c     = '0;

    prev_inc_c = prev_bin + CBITS'(1);
    stall_c    = (dec_c == prev_bin);
    skip_c     = !stall_c && (dec_c != prev_inc_c);
    sigmis_c   = sig_in != (gray_in == '0);
    wrap_c     = in_vld && (state != UNLOCKED) &&
                 (prev_bin == CNT_MAX) && (dec_c == '0);

    fail_c[ERR_SKIP]   = skip_c;
    fail_c[ERR_SIGMIS] = sigmis_c;
    fail_c[ERR_STALL]  = stall_c;
  end

  // Decode register, wrap tracking and lock/fault state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      prev_bin   <= '0;
      bin_out    <= '0;
      bin_vld    <= 1'b0;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      bin_vld    <= in_vld;
      wrap_pulse <= wrap_c;

      if (in_vld) begin
        bin_out  <= dec_c;
        prev_bin <= dec_c;
      end

      // Wrap counter survives clr_err; only reset clears it
      if (wrap_c && (wrap_cnt != WRAP_MAX)) begin
        wrap_cnt <= wrap_cnt + WRAP_BITS'(1);
      end

      if (clr_err) begin
        // Clear wins over any same-cycle failure; next valid sample re-seeds
        state    <= UNLOCKED;
        locked   <= 1'b0;
        err      <= 1'b0;
        err_code <= '0;
      end else if (in_vld) begin
        case (state)
          UNLOCKED: begin
            // Only the zero-marker check is meaningful on the seed sample
            if (sigmis_c) begin
              state                <= FAULT;
              err                  <= 1'b1;
              err_code[ERR_SIGMIS] <= 1'b1;
            end else begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (|fail_c) begin
              state    <= FAULT;
              locked   <= 1'b0;
              err      <= 1'b1;
              err_code <= err_code | fail_c;
            end
          end
          FAULT: begin
            err_code <= err_code | fail_c;
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Randomized and directed checks of gray_seq_monitor (CBITS=4, WRAP_BITS=2)
// against a behavioural reference model.
module tb_gray_seq_monitor;

  localparam int unsigned CBITS     = 4;
  localparam int unsigned WRAP_BITS = 2;
  localparam int          NCNT      = 1 << CBITS;
  localparam int          WMAX      = (1 << WRAP_BITS) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 in_vld;
  logic [CBITS-1:0]     gray_in;
  logic                 sig_in;
  logic                 clr_err;
  logic [CBITS-1:0]     bin_out;
  logic                 bin_vld;
  logic [WRAP_BITS-1:0] wrap_cnt;
  logic                 wrap_pulse;
  logic                 locked;
  logic                 err;
  logic [2:0]           err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: mode 0 = unlocked, 1 = locked, 2 = fault
  int m_mode, m_prev, m_code, m_wcnt, m_bin, m_bvld, m_wp;

  gray_seq_monitor #(
    .CBITS(CBITS),
    .WRAP_BITS(WRAP_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .gray_in    (gray_in),
    .sig_in     (sig_in),
    .clr_err    (clr_err),
    .bin_out    (bin_out),
    .bin_vld    (bin_vld),
    .wrap_cnt   (wrap_cnt),
    .wrap_pulse (wrap_pulse),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % NCNT;
  endfunction

  // Decode by search: the binary value whose Gray image matches
  function automatic int from_gray(input int g);
    for (int k = 0; k < NCNT; k++) begin
      if (to_gray(k) == g) return k;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the given inputs
  task automatic model(input bit rst, input bit vld, input int g, input bit sig, input bit clr);
    int b, f;
    if (rst) begin
      m_mode = 0; m_prev = 0; m_code = 0; m_wcnt = 0;
      m_bin = 0; m_bvld = 0; m_wp = 0;
      return;
    end
    m_bvld = vld;
    m_wp   = 0;
    if (vld) begin
      b = from_gray(g);
      if (m_mode != 0 && m_prev == NCNT - 1 && b == 0) begin
        m_wp = 1;
        if (m_wcnt < WMAX) m_wcnt++;
      end
      if (!clr) begin
        f = 0;
        if (b != m_prev && b != (m_prev + 1) % NCNT) f |= 1;
        if (int'(sig) != int'(g == 0))               f |= 2;
        if (b == m_prev)                             f |= 4;
        if (m_mode == 0) begin
          if ((f & 2) != 0) begin m_mode = 2; m_code |= 2; end
          else m_mode = 1;
        end else if (f != 0) begin
          m_mode = 2;
          m_code |= f;
        end
      end
      m_prev = b;
      m_bin  = b;
    end
    if (clr) begin
      m_mode = 0;
      m_code = 0;
    end
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic step(input bit rst, input bit vld, input int g, input bit sig, input bit clr);
    rst_n   = !rst;
    in_vld  = vld;
    gray_in = CBITS'(g);
    sig_in  = sig;
    clr_err = clr;
    @(posedge clk);
    #1;
    model(rst, vld, g, sig, clr);
    check("bin_out",    int'(bin_out),    m_bin);
    check("bin_vld",    int'(bin_vld),    m_bvld);
    check("wrap_cnt",   int'(wrap_cnt),   m_wcnt);
    check("wrap_pulse", int'(wrap_pulse), m_wp);
    check("locked",     int'(locked),     int'(m_mode == 1));
    check("err",        int'(err),        int'(m_mode == 2));
    check("err_code",   int'(err_code),   m_code);
  endtask

  // Clean sample of binary count b
  task automatic cnt(input int b);
    step(0, 1, to_gray(b % NCNT), (b % NCNT) == 0, 0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, nb;
    rst_n = 1'b0; in_vld = 1'b0; gray_in = '0; sig_in = 1'b0; clr_err = 1'b0;
    m_mode = 0; m_prev = 0; m_code = 0; m_wcnt = 0; m_bin = 0; m_bvld = 0; m_wp = 0;

    // Reset, then 20 clean samples 0..15,0..3
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cnt(i);
    check("clean_wrap_cnt", int'(wrap_cnt), 1);

    // Skip: ..bin5 (gray 7), gray 5 (bin 6), gray 13 (bin 9)
    cnt(4); cnt(5);
    step(0, 1, 5, 0, 0);
    step(0, 1, 13, 0, 0);
    check("skip_code", int'(err_code), 1);

    // Stall: re-seed, then gray 6 twice
    step(0, 0, 0, 0, 1);
    cnt(3); cnt(4); cnt(4);
    check("stall_code", int'(err_code), 4);

    // Clear, then samples 4,5
    step(0, 0, 0, 0, 1);
    check("clr_err_flag", int'(err), 0);
    cnt(4); cnt(5);
    check("relock", int'(locked), 1);

    // Missing zero marker at a wrap, then a skip with a false marker in FAULT
    for (int b = 6; b < NCNT; b++) cnt(b);
    step(0, 1, 0, 0, 0);
    check("sigmis_code", int'(err_code), 2);
    step(0, 1, 3, 1, 0);
    check("accum_code", int'(err_code), 3);

    // Five full wraps saturate the wrap counter; clr_err keeps it
    step(0, 0, 0, 0, 1);
    for (int i = 0; i <= 5 * NCNT; i++) cnt(i);
    check("wrap_sat", int'(wrap_cnt), WMAX);
    step(0, 0, 0, 0, 1);
    check("wrap_keep", int'(wrap_cnt), WMAX);

    // Ten-cycle gap mid-sequence is not a fault
    cnt(7); cnt(8); cnt(9);
    gap(10);
    cnt(10); cnt(11);
    check("gap_no_err", int'(err), 0);

    // Fault, reset for one cycle, then re-seed
    step(0, 1, to_gray(2), 0, 0);
    step(1, 1, to_gray(5), 1, 1);
    cnt(6); cnt(7);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      nb = (m_prev + 1) % NCNT;
      if (r < 60)       cnt(nb);
      else if (r < 68)  gap(int'($urandom_range(1, 3)));
      else if (r < 75)  cnt(m_prev);
      else if (r < 83)  step(0, 1, int'($urandom_range(0, NCNT - 1)), 1'($urandom_range(0, 1)), 0);
      else if (r < 90)  step(0, 1'($urandom_range(0, 1)), to_gray(nb), nb == 0, 1);
      else if (r < 92)  step(1, 1'($urandom_range(0, 1)), to_gray(nb), nb == 0, 1'($urandom_range(0, 1)));
      else              step(0, 1, to_gray(nb), nb != 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
